// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the register-file write port: merges 1-cycle ALU results
// with buffered load results and tracks outstanding load destinations for decode.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        hazard,
  output logic        we,
  output logic [4:0]  addrw,
  output logic [31:0] wdata,
  output logic [4:0]  fifo_count,
  output logic        err_drop
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [3:0]  LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  // Registers 0, 1 and 31 are hardwired: never written, never pending.
  function automatic logic is_hw(input logic [4:0] a);
    return (a == 5'd0) || (a == 5'd1) || (a == 5'd31);
  endfunction

  logic [4:0]    mem_addr [FIFO_DEPTH];
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [3:0]    starve_cnt;
  logic [31:0]   pending;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          alu_win;
  logic          alu_lost;
  logic          win_valid;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic [4:0]    win_addr;
  logic [31:0]   win_data;
  logic [3:0]    starve_next;
  logic          stall_next;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;

  assign fifo_empty = (count == 5'd0);
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_count = count;
  assign head_addr  = mem_addr[rd_ptr];
  assign head_data  = mem_data[rd_ptr];

  // Load handshake: a result transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready depends only on current occupancy, so a pop at full never frees a slot
  // for the same cycle; it is held low throughout reset.
  assign ld_ready = rst & ~fifo_full;
  assign push     = ld_valid & ld_ready;

  always_comb begin
    pop      = 1'b0;
    alu_win  = 1'b0;
    alu_lost = 1'b0;
    if (alu_stall) begin
      pop      = ~fifo_empty;
      alu_lost = alu_valid;
    end else if (alu_valid) begin
      alu_win = 1'b1;
    end else begin
      pop = ~fifo_empty;
    end
  end

  assign win_valid = pop | alu_win;
  assign win_addr  = pop ? head_addr : alu_addr;
  assign win_data  = pop ? head_data : alu_data;

  // Starvation: count ALU wins over a waiting head; on the limit grant one stall cycle.
  always_comb begin
    starve_next = starve_cnt;
    stall_next  = 1'b0;
    if (pop || fifo_empty) begin
      starve_next = 4'd0;
    end else if (alu_win) begin
      if (starve_cnt == LIMIT_M1) begin
        stall_next  = 1'b1;
        starve_next = 4'd0;
      end else begin
        starve_next = starve_cnt + 4'd1;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue to the popped register stays pending.
  assign pend_clr = pop ? (32'd1 << head_addr) : 32'd0;
  assign pend_set = (issue_valid && !is_hw(issue_addr)) ? (32'd1 << issue_addr) : 32'd0;

  assign hazard = (pending[chk_addr1] & ~is_hw(chk_addr1)) |
                  (pending[chk_addr2] & ~is_hw(chk_addr2));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= ld_addr;
      mem_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 5'd0;
      starve_cnt <= 4'd0;
      alu_stall  <= 1'b0;
      pending    <= 32'd0;
      we         <= 1'b0;
      addrw      <= 5'd0;
      wdata      <= 32'd0;
      err_drop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      alu_stall  <= stall_next;
      pending    <= ((pending & ~pend_clr) | pend_set) & 32'h7fff_fffc;
      // addrw/wdata follow any winner (even a hardwired target); we gates the write.
      we <= win_valid & ~is_hw(win_addr);
      if (win_valid) begin
        addrw <= win_addr;
        wdata <= win_data;
      end
      if (alu_lost) err_drop <= 1'b1;
    end
  end

endmodule
